// File: rtl/keypad_scan_fifo_pkg.sv
// Shared types and constants for the keypad scanner: FSM states, key codes,
// the "no key" frame encoding and the dout field layout.
package keypad_scan_fifo_pkg;

  typedef enum logic [1:0] {
    KS_IDLE    = 2'd0,
    KS_CONFIRM = 2'd1,
    KS_HELD    = 2'd2,
    KS_RELEASE = 2'd3
  } key_state_e;

  typedef logic [3:0] key_code_t;

  // Frame results carry a key code in [3:0]; bit 4 set means no key was seen.
  typedef logic [4:0] frame_result_t;
  localparam frame_result_t NO_KEY = 5'h10;

  localparam int DOUT_PENDING_BIT  = 7;
  localparam int DOUT_OVERFLOW_BIT = 6;
  localparam int DOUT_KEY_LSB      = 0;

  // Returns {found, col} for the lowest-numbered pressed column.
  function automatic logic [2:0] lowest_col(input logic [3:0] pressed);
    logic [2:0] res;
    if (pressed[0]) begin
      res = 3'b100;
    end else if (pressed[1]) begin
      res = 3'b101;
    end else if (pressed[2]) begin
      res = 3'b110;
    end else if (pressed[3]) begin
      res = 3'b111;
    end else begin
      res = 3'b000;
    end
    return res;
  endfunction

endpackage

// File: rtl/keypad_scan_fifo_key_fifo.sv
// Small key-code FIFO with an extra pointer bit for occupancy; head, full and
// empty are registered from next-state so they follow a push/pop by one cycle.
module key_fifo
  import keypad_scan_fifo_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW:0]      wr_ptr_r;
  logic [AW:0]      rd_ptr_r;
  logic [AW:0]      wr_next_s;
  logic [AW:0]      rd_next_s;
  logic             full_r;
  logic             empty_r;
  logic [WIDTH-1:0] head_r;
  logic [WIDTH-1:0] head_next_s;
  logic             push_ok_s;
  logic             pop_ok_s;

  // Accept decisions, next pointers and the head that will be visible next cycle.
  always_comb begin
    pop_ok_s  = pop && !empty_r;
    push_ok_s = push && (!full_r || pop_ok_s);
    rd_next_s = pop_ok_s ? (rd_ptr_r + PTR_ONE) : rd_ptr_r;
    wr_next_s = push_ok_s ? (wr_ptr_r + PTR_ONE) : wr_ptr_r;
    if (rd_next_s == wr_next_s) begin
      head_next_s = {WIDTH{1'b0}};
    end else if (push_ok_s && (rd_next_s[AW-1:0] == wr_ptr_r[AW-1:0])) begin
      // The entry being written becomes the head in the same cycle.
      head_next_s = din;
    end else begin
      head_next_s = mem_r[rd_next_s[AW-1:0]];
    end
  end

  // Storage, pointers and registered status outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {WIDTH{1'b0}};
      end
      wr_ptr_r <= {(AW+1){1'b0}};
      rd_ptr_r <= {(AW+1){1'b0}};
      full_r   <= 1'b0;
      empty_r  <= 1'b1;
      head_r   <= {WIDTH{1'b0}};
    end else begin
      if (push_ok_s) begin
        mem_r[wr_ptr_r[AW-1:0]] <= din;
      end
      wr_ptr_r <= wr_next_s;
      rd_ptr_r <= rd_next_s;
      empty_r  <= (rd_next_s == wr_next_s);
      full_r   <= (rd_next_s[AW] != wr_next_s[AW]) &&
                  (rd_next_s[AW-1:0] == wr_next_s[AW-1:0]);
      head_r   <= head_next_s;
    end
  end

  assign full  = full_r;
  assign empty = empty_r;
  assign head  = head_r;

endmodule

// File: rtl/keypad_scan_fifo.sv
// 4x4 keypad scanner: row drive, column synchronizer, per-frame lowest-key
// detection, press/release debounce FSM and a key-code FIFO with sticky overflow.
module keypad_scan_fifo
  import keypad_scan_fifo_pkg::*;
#(
  parameter int SCAN_DIV       = 50000,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic       clk,
  input  logic       reset,
  output logic [3:0] rows,
  input  logic [3:0] cols,
  input  logic       rd_en,
  output logic [7:0] dout,
  output logic       key_pending
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
  localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_TARGET = CNT_W'(DEBOUNCE_SCANS);

  logic [DIV_W-1:0] div_r;
  logic [1:0]       row_r;
  logic [3:0]       rows_r;
  logic [3:0]       cols_meta_r;
  logic [3:0]       cols_sync_r;
  frame_result_t    best_r;
  key_state_e       state_r;
  key_code_t        cand_r;
  logic [CNT_W-1:0] count_r;
  logic             overflow_r;

  logic             dwell_end_s;
  logic             frame_end_s;
  logic [2:0]       col_hit_s;
  frame_result_t    frame_s;
  logic             push_s;
  logic             pop_ok_s;
  logic             fifo_full_s;
  logic             fifo_empty_s;
  key_code_t        fifo_head_s;

  // Two-flop synchronizer for the asynchronous, pulled-up column inputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cols_meta_r <= 4'hF;
      cols_sync_r <= 4'hF;
    end else begin
      cols_meta_r <= cols;
      cols_sync_r <= cols_meta_r;
    end
  end

  // Dwell end detection and running lowest-key merge across the frame.
  always_comb begin
    dwell_end_s = (div_r == DIV_LAST);
    frame_end_s = dwell_end_s && (row_r == 2'd3);
    col_hit_s   = lowest_col(~cols_sync_r);
    if ((row_r != 2'd0) && (best_r != NO_KEY)) begin
      frame_s = best_r;
    end else if (col_hit_s[2]) begin
      frame_s = {1'b0, row_r, col_hit_s[1:0]};
    end else begin
      frame_s = NO_KEY;
    end
  end

  // Row dwell timer, row drive and per-frame accumulator.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_r  <= {DIV_W{1'b0}};
      row_r  <= 2'd0;
      rows_r <= 4'b1110;
      best_r <= NO_KEY;
    end else if (dwell_end_s) begin
      div_r  <= {DIV_W{1'b0}};
      row_r  <= row_r + 2'd1;
      rows_r <= ~(4'b0001 << (row_r + 2'd1));
      best_r <= frame_end_s ? NO_KEY : frame_s;
    end else begin
      div_r  <= div_r + DIV_ONE;
    end
  end

  // Push strobe lands on the frame-end cycle that completes a press debounce.
  always_comb begin
    push_s = 1'b0;
    if (frame_end_s && (frame_s != NO_KEY)) begin
      case (state_r)
        KS_IDLE:    push_s = (CNT_TARGET == CNT_ONE);
        KS_CONFIRM: push_s = (frame_s == {1'b0, cand_r}) && ((count_r + CNT_ONE) == CNT_TARGET);
        default:    push_s = 1'b0;
      endcase
    end else begin
      push_s = 1'b0;
    end
  end

  // Key debounce FSM, evaluated once per frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= KS_IDLE;
      cand_r  <= 4'h0;
      count_r <= CNT_ZERO;
    end else if (frame_end_s) begin
      case (state_r)
        KS_IDLE: begin
          if (frame_s != NO_KEY) begin
            cand_r <= frame_s[3:0];
            if (CNT_TARGET == CNT_ONE) begin
              state_r <= KS_HELD;
              count_r <= CNT_ZERO;
            end else begin
              state_r <= KS_CONFIRM;
              count_r <= CNT_ONE;
            end
          end
        end
        KS_CONFIRM: begin
          if (frame_s == {1'b0, cand_r}) begin
            if ((count_r + CNT_ONE) == CNT_TARGET) begin
              state_r <= KS_HELD;
              count_r <= CNT_ZERO;
            end else begin
              count_r <= count_r + CNT_ONE;
            end
          end else begin
            state_r <= KS_IDLE;
            count_r <= CNT_ZERO;
          end
        end
        KS_HELD: begin
          if (frame_s == NO_KEY) begin
            if (CNT_TARGET == CNT_ONE) begin
              state_r <= KS_IDLE;
              count_r <= CNT_ZERO;
            end else begin
              state_r <= KS_RELEASE;
              count_r <= CNT_ONE;
            end
          end
        end
        KS_RELEASE: begin
          if (frame_s == NO_KEY) begin
            if ((count_r + CNT_ONE) == CNT_TARGET) begin
              state_r <= KS_IDLE;
              count_r <= CNT_ZERO;
            end else begin
              count_r <= count_r + CNT_ONE;
            end
          end else begin
            state_r <= KS_HELD;
            count_r <= CNT_ZERO;
          end
        end
        default: begin
          state_r <= KS_IDLE;
          count_r <= CNT_ZERO;
        end
      endcase
    end
  end

  key_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (4)
  ) u_key_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_s),
    .pop   (rd_en),
    .din   (frame_s[3:0]),
    .full  (fifo_full_s),
    .empty (fifo_empty_s),
    .head  (fifo_head_s)
  );

  assign pop_ok_s = rd_en && !fifo_empty_s;

  // Sticky overflow: set by a dropped push, cleared by any accepted pop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow_r <= 1'b0;
    end else if (pop_ok_s) begin
      overflow_r <= 1'b0;
    end else if (push_s && fifo_full_s) begin
      overflow_r <= 1'b1;
    end else begin
      overflow_r <= overflow_r;
    end
  end

  assign rows = rows_r;
  assign key_pending = ~fifo_empty_s;

  always_comb begin
    dout = 8'h00;
    dout[DOUT_PENDING_BIT]              = ~fifo_empty_s;
    dout[DOUT_OVERFLOW_BIT]             = overflow_r;
    dout[DOUT_KEY_LSB+3:DOUT_KEY_LSB]   = fifo_head_s;
  end

endmodule

// File: tb/tb_keypad_scan_fifo.sv
// Randomized and directed bench for keypad_scan_fifo; a keypad matrix model drives
// cols from rows, and a frame-level reference model predicts dout every cycle.
module tb_keypad_scan_fifo;

  localparam int SCAN_DIV = 4;
  localparam int DEB      = 2;
  localparam int DEPTH    = 4;
  localparam int FRAME    = 4 * SCAN_DIV;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       rd_en = 1'b0;
  logic [3:0] rows;
  logic [3:0] cols;
  logic [7:0] dout;
  logic       key_pending;
  logic [15:0] pressed = 16'h0000;

  int errors = 0;
  int checks = 0;
  int edge_n = 0;

  int q[$];
  bit ovf = 1'b0;
  bit held = 1'b0;
  int cand = 0;
  int streak = 0;
  int rel = 0;

  always #5 clk = ~clk;

  keypad_scan_fifo #(
    .SCAN_DIV       (SCAN_DIV),
    .DEBOUNCE_SCANS (DEB),
    .FIFO_DEPTH     (DEPTH)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .rows        (rows),
    .cols        (cols),
    .rd_en       (rd_en),
    .dout        (dout),
    .key_pending (key_pending)
  );

  // A pressed key shorts its row line to its column line.
  always_comb begin
    cols = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (!rows[r] && pressed[r*4+c]) cols[c] = 1'b0;
      end
    end
  end

  task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h (edge %0d)", tag, got, want, edge_n);
    end
  endtask

  function automatic logic [15:0] key_bit(input int k);
    logic [15:0] b;
    b = 16'h0001;
    return b << k;
  endfunction

  function automatic int frame_code(input logic [15:0] p);
    for (int i = 0; i < 16; i++) begin
      if (p[i]) return i;
    end
    return -1;
  endfunction

  // Reference behaviour at one clock edge: debounce once per frame, then the queue.
  task automatic model_edge(input bit rd, input bit frame_end, input logic [15:0] p);
    bit push;
    int code;
    push = 1'b0;
    code = frame_code(p);
    if (frame_end) begin
      if (!held) begin
        if (streak == 0) begin
          if (code >= 0) begin
            cand = code;
            streak = 1;
          end
        end else if (code == cand) begin
          streak++;
        end else begin
          streak = 0;
        end
        if (streak >= DEB) begin
          push = 1'b1;
          held = 1'b1;
          streak = 0;
          rel = 0;
        end
      end else begin
        if (code < 0) begin
          rel++;
          if (rel >= DEB) begin
            held = 1'b0;
            rel = 0;
          end
        end else begin
          rel = 0;
        end
      end
    end
    if (rd && q.size() > 0) begin
      void'(q.pop_front());
      ovf = 1'b0;
    end
    if (push) begin
      if (q.size() < DEPTH) q.push_back(cand);
      else ovf = 1'b1;
    end
  endtask

  task automatic step(input bit rd);
    logic [7:0] exp_d;
    logic [3:0] exp_rows;
    rd_en = rd;
    @(posedge clk);
    edge_n++;
    model_edge(rd, (edge_n % FRAME) == 0, pressed);
    #1;
    rd_en = 1'b0;
    if (q.size() > 0) exp_d = {1'b1, ovf, 2'b00, 4'(q[0])};
    else exp_d = {1'b0, ovf, 6'b000000};
    exp_rows = ~(4'b0001 << ((edge_n / SCAN_DIV) % 4));
    check_val("dout", dout, exp_d);
    check_val("key_pending", {7'd0, key_pending}, {7'd0, exp_d[7]});
    check_val("rows", {4'h0, rows}, {4'h0, exp_rows});
  endtask

  task automatic run_frame(input logic [15:0] p, input logic [15:0] rd_mask);
    pressed = p;
    for (int j = 0; j < FRAME; j++) step(rd_mask[j]);
  endtask

  task automatic press(input logic [15:0] p, input int n);
    for (int i = 0; i < n; i++) run_frame(p, 16'h0000);
    for (int i = 0; i < DEB; i++) run_frame(16'h0000, 16'h0000);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    rd_en = 1'b0;
    pressed = 16'h0000;
    #1;
    check_val("rst_dout", dout, 8'h00);
    check_val("rst_rows", {4'h0, rows}, 8'h0E);
    check_val("rst_pending", {7'd0, key_pending}, 8'h00);
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_hold_dout", dout, 8'h00);
    check_val("rst_hold_rows", {4'h0, rows}, 8'h0E);
    q.delete();
    ovf = 1'b0;
    held = 1'b0;
    streak = 0;
    rel = 0;
    cand = 0;
    edge_n = 0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    logic [15:0] p;
    logic [15:0] m;
    int sel;
    int hold;

    #1;
    do_reset();

    // Steady press of row1/col2 for three frames.
    run_frame(key_bit(6), 16'h0000);
    run_frame(key_bit(6), 16'h0000);
    run_frame(key_bit(6), 16'h0000);
    check_val("held6_dout", dout, 8'h86);
    check_val("held6_pending", {7'd0, key_pending}, 8'h01);
    press(16'h0000, 1);
    run_frame(16'h0000, 16'h0001);
    check_val("drain6_dout", dout, 8'h00);

    // One-frame glitch is rejected.
    press(key_bit(6), 1);
    check_val("glitch_pending", {7'd0, key_pending}, 8'h00);

    // Five keys without reads: fifth dropped, overflow sticky.
    press(key_bit(0), 2);
    press(key_bit(5), 2);
    press(key_bit(10), 2);
    press(key_bit(15), 2);
    press(key_bit(11), 2);
    check_val("overflow_dout", dout, 8'hC0);
    run_frame(16'h0000, 16'h0001);
    check_val("pop_clears_ovf", dout, 8'h85);

    // Fill to full, then push coincident with a pop at the frame-end edge.
    press(key_bit(1), 2);
    check_val("full_dout", dout, 8'h85);
    run_frame(key_bit(2), 16'h0000);
    run_frame(key_bit(2), 16'h8000);
    check_val("push_pop_full", dout, 8'h8A);
    run_frame(16'h0000, 16'h0000);
    run_frame(16'h0000, 16'h0000);
    run_frame(16'h0000, 16'h0001);
    check_val("order_after_full", dout, 8'h8F);

    // Two keys together: only the lowest code is queued, once.
    run_frame(16'h0000, 16'hFFFF);
    press(key_bit(3) | key_bit(12), 4);
    check_val("rollover_dout", dout, 8'h83);
    run_frame(16'h0000, 16'h0001);
    check_val("rollover_single", dout, 8'h00);

    // Reset during a confirm with keys queued.
    press(key_bit(1), 2);
    press(key_bit(2), 2);
    run_frame(key_bit(7), 16'h0000);
    pressed = key_bit(7);
    for (int j = 0; j < 5; j++) step(1'b0);
    do_reset();
    press(key_bit(9), 2);
    check_val("post_reset_key", dout, 8'h89);
    run_frame(16'h0000, 16'h0001);
    check_val("post_reset_only", dout, 8'h00);

    // Randomized patterns and reads against the model.
    for (int f = 0; f < 60; f++) begin
      sel = $urandom_range(0, 19);
      if (sel < 9) p = 16'h0000;
      else if (sel < 16) p = key_bit($urandom_range(0, 15));
      else p = key_bit($urandom_range(0, 15)) | key_bit($urandom_range(0, 15));
      hold = $urandom_range(1, 3);
      for (int h = 0; h < hold; h++) begin
        m = 16'h0000;
        if ($urandom_range(0, 2) == 0) m = key_bit($urandom_range(0, 15));
        run_frame(p, m);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
